// File: rtl/coverfloat_vector_assembler.sv
// Reassembles 26-word coverfloat frames from a 32-bit word stream and presents
// each complete record through a valid/ready handshake, with framing statistics.
module coverfloat_vector_assembler #(
  parameter int FRAME_CNT_W = 32,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            op,
  output logic [7:0]             rm,
  output logic [127:0]           a,
  output logic [127:0]           b,
  output logic [127:0]           c,
  output logic [7:0]             operandFmt,
  output logic [127:0]           result,
  output logic [7:0]             resultFmt,
  output logic                   intermS,
  output logic [31:0]            intermX,
  output logic [191:0]           intermM,
  output logic [7:0]             exceptionBits,
  output logic                   err_short,
  output logic                   err_long,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [ERR_CNT_W-1:0]   err_count
);

  // state     | meaning
  // S_COLLECT | accepting words of a frame into the field registers
  // S_HOLD    | complete record presented, waiting for the consumer
  // S_DROP    | discarding the tail of an over-long frame up to in_last
  typedef enum logic [1:0] {S_COLLECT, S_HOLD, S_DROP} state_t;

  localparam logic [4:0] LAST_IDX = 5'd25;

  state_t                 r_state, w_state_nxt;
  logic [4:0]             r_idx, w_idx_nxt;
  logic                   w_short, w_long, w_hs, w_store;
  logic [1:0]             w_lane;
  logic [2:0]             w_mlane;

  logic [31:0]            r_op, r_intermX;
  logic [7:0]             r_rm, r_operandFmt, r_resultFmt, r_exceptionBits;
  logic [127:0]           r_a, r_b, r_c, r_result;
  logic                   r_intermS;
  logic [191:0]           r_intermM;
  logic                   r_err_short, r_err_long;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic [ERR_CNT_W-1:0]   r_err_count;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_hs        = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = 5'd0;
            if (in_last) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_long      = 1'b1;
              w_state_nxt = S_DROP;
            end
          end else if (in_last) begin
            w_short   = 1'b1;
            w_idx_nxt = 5'd0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_COLLECT;
      r_idx         <= 5'd0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_err_short <= w_short;
      r_err_long  <= w_long;
      if (w_hs) r_frame_count <= r_frame_count + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      if ((w_short || w_long) && (r_err_count != {ERR_CNT_W{1'b1}}))
        r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Operand/result groups start at idx 2,6,10,14, so idx[1:0]-2 is the word lane.
  assign w_store = (r_state == S_COLLECT) && in_valid;
  assign w_lane  = r_idx[1:0] - 2'd2;
  assign w_mlane = 3'(r_idx - 5'd20);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op            <= '0;
      r_rm            <= '0;
      r_operandFmt    <= '0;
      r_resultFmt     <= '0;
      r_exceptionBits <= '0;
      r_a             <= '0;
      r_b             <= '0;
      r_c             <= '0;
      r_result        <= '0;
      r_intermX       <= '0;
      r_intermS       <= 1'b0;
      r_intermM       <= '0;
    end else if (w_store) begin
      if (r_idx == 5'd0) begin
        r_op <= in_data;
      end else if (r_idx == 5'd1) begin
        r_rm            <= in_data[31:24];
        r_operandFmt    <= in_data[23:16];
        r_resultFmt     <= in_data[15:8];
        r_exceptionBits <= in_data[7:0];
      end else if (r_idx <= 5'd5) begin
        r_a[{w_lane, 5'd0} +: 32] <= in_data;
      end else if (r_idx <= 5'd9) begin
        r_b[{w_lane, 5'd0} +: 32] <= in_data;
      end else if (r_idx <= 5'd13) begin
        r_c[{w_lane, 5'd0} +: 32] <= in_data;
      end else if (r_idx <= 5'd17) begin
        r_result[{w_lane, 5'd0} +: 32] <= in_data;
      end else if (r_idx == 5'd18) begin
        r_intermX <= in_data;
      end else if (r_idx == 5'd19) begin
        r_intermS <= in_data[0];
      end else if (r_idx <= LAST_IDX) begin
        r_intermM[{w_mlane, 5'd0} +: 32] <= in_data;
      end
    end
  end

  assign op            = r_op;
  assign rm            = r_rm;
  assign a             = r_a;
  assign b             = r_b;
  assign c             = r_c;
  assign operandFmt    = r_operandFmt;
  assign result        = r_result;
  assign resultFmt     = r_resultFmt;
  assign intermS       = r_intermS;
  assign intermX       = r_intermX;
  assign intermM       = r_intermM;
  assign exceptionBits = r_exceptionBits;
  assign err_short     = r_err_short;
  assign err_long      = r_err_long;
  assign frame_count   = r_frame_count;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_coverfloat_vector_assembler.sv
// Bench for coverfloat_vector_assembler: frame table with scoreboarded records,
// plus hold, reset and error-counter saturation sequences.
module tb_coverfloat_vector_assembler;

  typedef struct {
    logic [31:0]  op;
    logic [7:0]   rm, ofmt, rfmt, exc;
    logic [127:0] a, b, c, res;
    logic         s;
    logic [31:0]  x;
    logic [191:0] m;
  } rec_t;

  typedef struct {
    int          len;
    logic [31:0] base;
    int          exp_fc;
    int          exp_ec;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 1;
  logic [31:0] in_data = '0;

  logic in_ready, out_valid, intermS, err_short, err_long;
  logic [31:0] op, intermX, frame_count;
  logic [7:0] rm, operandFmt, resultFmt, exceptionBits;
  logic [127:0] a, b, c, result;
  logic [191:0] intermM;
  logic [15:0] err_count;

  logic s_in_ready, s_out_valid, s_intermS, s_err_short, s_err_long;
  logic [31:0] s_op, s_intermX, s_frame_count;
  logic [7:0] s_rm, s_operandFmt, s_resultFmt, s_exceptionBits;
  logic [127:0] s_a, s_b, s_c, s_result;
  logic [191:0] s_intermM;
  logic [1:0] s_err_count;

  int n_pass = 0, n_total = 0;
  int ov_cycles = 0, short_cnt = 0, long_cnt = 0, s_short_cnt = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  coverfloat_vector_assembler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rm(rm), .a(a), .b(b), .c(c), .operandFmt(operandFmt), .result(result),
    .resultFmt(resultFmt), .intermS(intermS), .intermX(intermX), .intermM(intermM),
    .exceptionBits(exceptionBits), .err_short(err_short), .err_long(err_long),
    .frame_count(frame_count), .err_count(err_count));

  coverfloat_vector_assembler #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .op(s_op), .rm(s_rm), .a(s_a), .b(s_b), .c(s_c), .operandFmt(s_operandFmt),
    .result(s_result), .resultFmt(s_resultFmt), .intermS(s_intermS), .intermX(s_intermX),
    .intermM(s_intermM), .exceptionBits(s_exceptionBits), .err_short(s_err_short),
    .err_long(s_err_long), .frame_count(s_frame_count), .err_count(s_err_count));

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic rec_t model(input logic [31:0] base);
    logic [31:0] w[26];
    rec_t r;
    for (int i = 0; i < 26; i++) w[i] = base + 32'(i);
    r.op = w[0];
    r.rm = w[1][31:24]; r.ofmt = w[1][23:16]; r.rfmt = w[1][15:8]; r.exc = w[1][7:0];
    r.a = {w[5], w[4], w[3], w[2]};
    r.b = {w[9], w[8], w[7], w[6]};
    r.c = {w[13], w[12], w[11], w[10]};
    r.res = {w[17], w[16], w[15], w[14]};
    r.x = w[18];
    r.s = w[19][0];
    r.m = {w[25], w[24], w[23], w[22], w[21], w[20]};
    return r;
  endfunction

  // Monitor: pulse/valid counters and scoreboard pop on the output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_short) short_cnt++;
      if (err_long) long_cnt++;
      if (s_err_short) s_short_cnt++;
      if (out_valid) ov_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_record", 1'b1, 1'b0);
        else begin
          rec_t e;
          e = sb.pop_front();
          check("op", op, e.op);
          check("rm", rm, e.rm);
          check("operandFmt", operandFmt, e.ofmt);
          check("resultFmt", resultFmt, e.rfmt);
          check("exceptionBits", exceptionBits, e.exc);
          check("a", a, e.a);
          check("b", b, e.b);
          check("c", c, e.c);
          check("result", result, e.res);
          check("intermX", intermX, e.x);
          check("intermS", intermS, e.s);
          check("intermM", intermM, e.m);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that took the word.
  task automatic send_word(input logic [31:0] d, input logic last);
    int t = 0;
    logic acc = 0;
    in_valid = 1; in_data = d; in_last = last;
    while (!acc && t < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) check("word_accept_timeout", 1'b0, 1'b1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_frame(input int len, input logic [31:0] base);
    if (len == 26) sb.push_back(model(base));
    for (int i = 0; i < len; i++) send_word(base + 32'(i), (i == len - 1));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 0; sb.delete(); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    rec_t e;
    int ov0, es0, el0, ss0;
    logic [1:0] exp_sat[5];

    vecs[0] = '{len: 26, base: 32'h1000_0000, exp_fc: 1, exp_ec: 0};
    vecs[1] = '{len: 7,  base: 32'h5555_0000, exp_fc: 1, exp_ec: 1};
    vecs[2] = '{len: 26, base: 32'hF3C5_7A00, exp_fc: 2, exp_ec: 1};
    vecs[3] = '{len: 30, base: 32'h7777_0000, exp_fc: 2, exp_ec: 2};
    vecs[4] = '{len: 26, base: 32'hFFFF_FFF0, exp_fc: 3, exp_ec: 2};
    vecs[5] = '{len: 1,  base: 32'h0BAD_0000, exp_fc: 3, exp_ec: 3};
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1;
    tick(1);

    foreach (vecs[k]) begin
      ov0 = ov_cycles; es0 = short_cnt; el0 = long_cnt;
      send_frame(vecs[k].len, vecs[k].base);
      if (vecs[k].len == 26) check("ov_latency", out_valid, 1'b1);
      tick(3);
      check("frame_count", frame_count, 32'(vecs[k].exp_fc));
      check("err_count", err_count, 16'(vecs[k].exp_ec));
      check("ov_cycles", 32'(ov_cycles - ov0), (vecs[k].len == 26) ? 1 : 0);
      check("short_pulses", 32'(short_cnt - es0), (vecs[k].len < 26) ? 1 : 0);
      check("long_pulses", 32'(long_cnt - el0), (vecs[k].len > 26) ? 1 : 0);
      check("sb_drained", 32'(sb.size()), 0);
    end

    // Long frame: err_long right after word 25, tail dropped.
    for (int i = 0; i < 25; i++) send_word(32'h3000_0000 + 32'(i), 1'b0);
    send_word(32'h3000_0019, 1'b0);
    check("err_long_pulse", err_long, 1'b1);
    check("err_count_long", err_count, 16'd4);
    for (int i = 26; i < 30; i++) send_word(32'h3000_0000 + 32'(i), (i == 29));
    tick(1);
    check("err_long_once", err_long, 1'b0);
    check("drop_no_valid", out_valid, 1'b0);

    // Short frame: err_short pulses exactly one cycle.
    send_frame(7, 32'h4444_0000);
    check("err_short_pulse", err_short, 1'b1);
    tick(1);
    check("err_short_once", err_short, 1'b0);
    check("err_count_short", err_count, 16'd5);

    // Held record stays stable while new input is offered and ignored.
    out_ready = 0;
    send_frame(26, 32'h2468_1357);
    e = model(32'h2468_1357);
    check("hold_valid", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = $urandom; in_last = 1'(i & 1);
      tick(1);
      check("hold_valid_stable", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_a", a, e.a);
      check("hold_intermM", intermM, e.m);
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    tick(1);
    check("release_valid_low", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("release_frame_count", frame_count, 32'd4);
    check("hold_no_errors", err_count, 16'd5);

    // Reset mid-frame.
    for (int i = 0; i < 13; i++) send_word(32'h6000_0000 + 32'(i), 1'b0);
    in_valid = 1; in_data = 32'h6000_000D;
    do_reset();
    in_valid = 0;
    check("rstmid_in_ready", in_ready, 1'b1);
    check("rstmid_frame_count", frame_count, 0);
    check("rstmid_err_count", err_count, 0);
    check("rstmid_op", op, 0);
    check("rstmid_a", a, 0);
    tick(1);
    rst_n = 1;
    tick(1);
    send_frame(26, 32'h0123_4567);
    tick(2);
    check("post_rst_fc", frame_count, 32'd1);

    // Reset while holding a record.
    out_ready = 0;
    send_frame(26, 32'h89AB_CDEF);
    check("hold2_valid", out_valid, 1'b1);
    do_reset();
    check("rsthold_valid", out_valid, 1'b0);
    check("rsthold_in_ready", in_ready, 1'b1);
    check("rsthold_fc", frame_count, 0);
    check("rsthold_op", op, 0);
    check("rsthold_intermM", intermM, 0);
    check("rsthold_intermX", intermX, 0);
    tick(1);
    rst_n = 1; out_ready = 1;
    tick(1);
    send_frame(26, 32'hCAFE_0000);
    tick(2);
    check("post_rst2_fc", frame_count, 32'd1);
    check("sb_empty_after_reset", 32'(sb.size()), 0);

    // Saturation of a 2-bit error counter.
    do_reset();
    tick(1);
    rst_n = 1;
    tick(1);
    ss0 = s_short_cnt;
    for (int k = 0; k < 5; k++) begin
      send_frame(2, 32'hE000_0000 + 32'(k << 8));
      check("sat_err_short", s_err_short, 1'b1);
      check("sat_err_count", s_err_count, exp_sat[k]);
      check("wide_err_count", err_count, 16'(k + 1));
    end
    tick(2);
    check("sat_pulses", 32'(s_short_cnt - ss0), 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coverfloat_vector_assembler.md
Name: coverfloat_vector_assembler

Overview:
- Receive side of the coverfloat record: consumes a 32-bit word stream of packed floating-point test vectors (from a file-reader DMA or a DUT-side serializer).
- Reassembles each 26-word frame into the full coverfloat record (op, rm, a/b/c, operandFmt, result, resultFmt, intermS/X/M, exceptionBits).
- Presents the record with a valid/ready handshake to the coverage sampling logic.
- Checks frame length, discards malformed frames, and keeps frame and error statistics.

Parameters:
- FRAME_CNT_W, 32, width of the accepted-frame counter (wraps).
- ERR_CNT_W, 16, width of the framing-error counter (saturates).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  32  packed word
- in_last  in  1  marks final word of a frame
- out_valid  out  1  assembled record available
- out_ready  in  1  consumer takes record when out_valid&&out_ready
- op  out  32  operation code
- rm  out  8  rounding mode
- a, b, c  out  128 each  operands
- operandFmt  out  8  operand format
- result  out  128  result
- resultFmt  out  8  result format
- intermS  out  1  intermediate sign
- intermX  out  32  intermediate exponent
- intermM  out  192  intermediate mantissa
- exceptionBits  out  8  exception flags
- err_short  out  1  one-cycle pulse: in_last seen before word 25
- err_long  out  1  one-cycle pulse: word 25 accepted without in_last
- frame_count  out  FRAME_CNT_W  good frames delivered
- err_count  out  ERR_CNT_W  framing errors, saturating

Behaviour:
- Word layout, index 0..25. Multi-word fields are sent least-significant word first.
  - 0: op
  - 1: {rm[31:24], operandFmt[23:16], resultFmt[15:8], exceptionBits[7:0]}
  - 2-5: a
  - 6-9: b
  - 10-13: c
  - 14-17: result
  - 18: intermX
  - 19: intermS in bit 0; bits 31:1 ignored
  - 20-25: intermM
- Each accepted word is written directly into its field register; a 5-bit index counter selects the destination.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - DROP: in_ready=1, out_valid=0; accepted words are discarded.
- COLLECT, word accepted at idx<25 with in_last=0: store the word, idx+1.
- COLLECT, word at idx<25 with in_last=1 (short frame):
  - Pulse err_short next cycle and increment err_count.
  - idx<-0; stay in COLLECT; the partial record is abandoned.
  - Field registers may hold stale data and are never presented.
- COLLECT, word at idx 25 with in_last=1: store the word, idx<-0, go to HOLD.
  - out_valid rises the cycle after the final word is accepted (latency 1 from last word).
- COLLECT, word at idx 25 with in_last=0 (long frame): pulse err_long, increment err_count, idx<-0, go to DROP.
- DROP: discard words until a word with in_last=1 is accepted (that word is discarded too), then go to COLLECT with idx=0.
- HOLD: record fields are stable while out_valid=1.
  - On out_valid&&out_ready: go to COLLECT, frame_count+1 (wraps).
  - out_valid falls the next cycle; in_ready rises the same cycle.
- No word is accepted in the cycle of the handshake. Maximum throughput is one frame per 27 cycles.
- in_valid is ignored whenever in_ready=0. Words are never lost or double-counted.
- err_count saturates at all-ones; err_short/err_long still pulse when it is saturated.
- Reset (async assert, any state including mid-frame or HOLD), all of the following cleared:
  - state COLLECT, idx 0, in_ready 1
  - out_valid 0, err_short 0, err_long 0
  - frame_count 0, err_count 0
  - all record fields 0
- A partial frame in progress is discarded.

Test Plan:
- 26 words, word i = 0x1000_0000+i, in_last on i=25, out_ready=1:
  - out_valid high exactly 1 cycle, 1 cycle after the last word
  - op=0x10000000; rm=0x10, operandFmt=0x00, resultFmt=0x00, exceptionBits=0x01
  - a=0x10000005_10000004_10000003_10000002; intermS=1; intermX=0x10000012
  - frame_count=1
- Same frame with out_ready held 0 for 10 cycles:
  - out_valid and fields stable, in_ready=0 throughout, new in_valid ignored
  - on release, the handshake is followed by in_ready=1 the next cycle
- 7-word frame with in_last on word 6, then a good frame:
  - err_short pulses once, err_count=1
  - good frame decodes correctly, frame_count=1
- 30-word frame with in_last on word 29:
  - err_long pulses after word 25
  - words 26-29 are dropped; no out_valid
  - next good frame decodes; err_count=1
- Reset asserted at word 13 of a frame and when in HOLD:
  - outputs and counters 0 immediately; in_ready=1
  - the next full frame decodes correctly
- With ERR_CNT_W=2, five short frames: err_count sequence 1,2,3,3,3; err_short pulses 5 times.
